// File: rtl/sine_rom_sequencer.sv
// Plays the sine table out of a synchronous sample ROM: paced address generation with modulo-DEPTH
// stepping, and realignment of the 1-cycle ROM latency into a sample/valid stream.
module sine_rom_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned DIV_WIDTH = 16,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [AW-1:0]        step,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [WIDTH-1:0]     rom_data,
  output logic [WIDTH-1:0]     sample,
  output logic                 sample_valid,
  output logic                 wrap,
  output logic                 busy
);

  localparam int unsigned SumW = AW + 1;
  localparam logic [SumW-1:0] DepthSum = SumW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [AW-1:0]        step_q, step_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 wrap_addr_q, wrap_addr_d;
  logic                 en_d1_q, en_d1_d;
  logic                 wrap_d1_q, wrap_d1_d;
  logic [WIDTH-1:0]     sample_q, sample_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 wrap_q, wrap_d;

  logic                 launch;
  logic [SumW-1:0]      addr_sum;
  logic                 addr_wrapped;
  logic [AW-1:0]        addr_next;

  // stop has priority over start in IDLE
  assign launch = (state_q == StIdle) && start && !stop;

  // Sum is one bit wider so the modulo-DEPTH compare works for non-power-of-2 DEPTH.
  always_comb begin
    addr_sum     = {1'b0, addr_q} + {1'b0, step_q};
    addr_wrapped = (addr_sum >= DepthSum);
    addr_next    = AW'(addr_wrapped ? (addr_sum - DepthSum) : addr_sum);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StRun;
      StRun:   if (stop) state_d = StDrain;
      StDrain: if (!en_d1_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    rom_en = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StRun: begin
        rom_en = (cnt_q == '0);
        busy   = 1'b1;
      end
      StDrain: busy = 1'b1;
      default: ;
    endcase
  end

  // Address generation and read pacing
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    step_d      = step_q;
    addr_d      = addr_q;
    wrap_addr_d = wrap_addr_q;
    if (launch) begin
      div_d       = div;
      step_d      = (step == '0) ? AW'(1) : step;
      cnt_d       = '0;
      addr_d      = '0;
      wrap_addr_d = 1'b0;
    end else if (state_q == StRun) begin
      if (rom_en) begin
        cnt_d       = div_q;
        addr_d      = addr_next;
        wrap_addr_d = addr_wrapped;
      end else begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
      end
    end
  end

  // Read-latency realignment
  always_comb begin
    en_d1_d        = rom_en;
    wrap_d1_d      = rom_en & wrap_addr_q;
    sample_d       = en_d1_q ? rom_data : sample_q;
    sample_valid_d = en_d1_q;
    wrap_d         = en_d1_q & wrap_d1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      div_q          <= '0;
      step_q         <= '0;
      addr_q         <= '0;
      wrap_addr_q    <= 1'b0;
      en_d1_q        <= 1'b0;
      wrap_d1_q      <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      step_q         <= step_d;
      addr_q         <= addr_d;
      wrap_addr_q    <= wrap_addr_d;
      en_d1_q        <= en_d1_d;
      wrap_d1_q      <= wrap_d1_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      wrap_q         <= wrap_d;
    end
  end

  assign rom_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign wrap         = wrap_q;

`ifndef SYNTHESIS
  // DRAIN only exits once the pipeline is empty, so no sample can appear while idle.
  a_valid_busy: assert property (@(posedge clk) disable iff (rst) sample_valid |-> busy);
`endif

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// Scoreboard bench for sine_rom_sequencer: expected read addresses are queued by the stimulus,
// a monitor checks each ROM read and each delivered sample against them.
module tb_sine_rom_sequencer;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned AW        = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic [DIV_WIDTH-1:0] div = '0;
  logic [AW-1:0]        step = '0;
  logic                 rom_en;
  logic [AW-1:0]        rom_addr;
  logic [WIDTH-1:0]     rom_data;
  logic [WIDTH-1:0]     sample;
  logic                 sample_valid;
  logic                 wrap;
  logic                 busy;

  sine_rom_sequencer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .div         (div),
    .step        (step),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .wrap        (wrap),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; bit wrap;} exp_rd_t;
  typedef struct {int due; logic [31:0] data; bit wrap;} exp_smp_t;

  exp_rd_t  ea_q[$];
  exp_smp_t smp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int play_id = 0;
  int exp_period = 1;
  logic [WIDTH-1:0] rom_q = '0;

  function automatic logic [31:0] mem_f(input int a);
    logic [7:0] lo;
    lo = 8'(a);
    return {8'h5A, lo ^ 8'h3C, 16'(a * 1021)};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_q <= mem_f(int'(rom_addr));
  end
  assign rom_data = rom_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every ROM read and every sample against the scoreboard.
  initial begin
    int seen_id = -1;
    int last_en = 0;
    exp_rd_t e;
    exp_smp_t s;
    forever begin
      @(negedge clk);
      if (rst) begin
        smp_q.delete();
      end else begin
        if (rom_en) begin
          if (seen_id == play_id) chk("cadence", 64'(cyc - last_en), 64'(exp_period));
          seen_id = play_id;
          last_en = cyc;
          if (ea_q.size() == 0) begin
            chk("unexpected_rom_en", 64'(rom_en), 64'(0));
          end else begin
            e = ea_q.pop_front();
            chk("rom_addr", 64'(rom_addr), 64'(e.addr));
            smp_q.push_back('{due: cyc + 2, data: mem_f(e.addr), wrap: e.wrap});
          end
        end
        if (sample_valid) begin
          if (smp_q.size() == 0) begin
            chk("unexpected_valid", 64'(sample_valid), 64'(0));
          end else begin
            s = smp_q.pop_front();
            chk("latency", 64'(cyc), 64'(s.due));
            chk("sample", 64'(sample), 64'(s.data));
            chk("wrap", 64'(wrap), 64'(s.wrap));
          end
        end else begin
          chk("wrap_no_valid", 64'(wrap), 64'(0));
        end
      end
    end
  end

  // Starts playback, stops in the cycle of the n-th read, then checks the drain sequence.
  task automatic play(input int d, input int s, input int n, input bit disturb);
    int seen = 0;
    bit done = 1'b0;
    play_id++;
    exp_period = d + 1;
    @(posedge clk); #1;
    div = 16'(d);
    step = 6'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = disturb;
    if (disturb) begin
      div = 16'd7;
      step = 6'd3;
    end
    for (int i = 0; i < n * (d + 1) + 20 && !done; i++) begin
      @(negedge clk);
      if (rom_en) begin
        seen++;
        if (seen == n) begin
          stop = 1'b1;
          start = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      chk("play_reads", 64'(seen), 64'(n));
      stop = 1'b1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'(1));
    chk("drain_rom_en", 64'(rom_en), 64'(0));
    @(negedge clk);
    chk("last_valid", 64'(sample_valid), 64'(1));
    chk("drain_busy2", 64'(busy), 64'(1));
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_valid", 64'(sample_valid), 64'(0));
    chk("reads_left", 64'(ea_q.size()), 64'(0));
    chk("samples_left", 64'(smp_q.size()), 64'(0));
  endtask

  initial begin
    int a5[15] = '{0, 5, 10, 15, 20, 25, 30, 35, 40, 45, 50, 55, 60, 1, 6};
    int seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_en", 64'(rom_en), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_sample", 64'(sample), 64'(0));
    chk("rst_valid", 64'(sample_valid), 64'(0));
    chk("rst_wrap", 64'(wrap), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // div=0, step=1: full sweep, wrap flagged only on the second read of address 0
    for (int i = 0; i < 66; i++) ea_q.push_back('{addr: i % 64, wrap: (i == 64)});
    play(0, 1, 66, 1'b0);

    // div=3, step=1: one read every 4 clocks
    for (int i = 0; i < 5; i++) ea_q.push_back('{addr: i, wrap: 1'b0});
    play(3, 1, 5, 1'b0);

    // div=0, step=5: 60 -> 1 wraps
    for (int i = 0; i < 15; i++) ea_q.push_back('{addr: a5[i], wrap: (i == 13)});
    play(0, 5, 15, 1'b0);

    // step=0 behaves as step=1
    for (int i = 0; i < 4; i++) ea_q.push_back('{addr: i, wrap: 1'b0});
    play(0, 0, 4, 1'b0);

    // Reset while a read is in flight
    play_id++;
    exp_period = 4;
    ea_q.push_back('{addr: 0, wrap: 1'b0});
    ea_q.push_back('{addr: 1, wrap: 1'b0});
    @(posedge clk); #1;
    div = 16'd3;
    step = 6'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      @(negedge clk);
      if (rom_en) seen++;
    end
    chk("rst_flight_reads", 64'(seen), 64'(2));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_rom_en", 64'(rom_en), 64'(0));
    chk("rstmid_rom_addr", 64'(rom_addr), 64'(0));
    chk("rstmid_sample", 64'(sample), 64'(0));
    chk("rstmid_valid", 64'(sample_valid), 64'(0));
    repeat (6) @(negedge clk);
    chk("rstmid_no_valid", 64'(smp_q.size()), 64'(0));

    // start and stop together in IDLE: stop wins
    @(posedge clk); #1;
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("startstop_busy", 64'(busy), 64'(0));
    chk("startstop_rom_en", 64'(rom_en), 64'(0));
    @(negedge clk);
    chk("startstop_busy2", 64'(busy), 64'(0));

    // div=1; start/div/step changes during RUN must be ignored
    for (int i = 0; i < 6; i++) ea_q.push_back('{addr: i, wrap: 1'b0});
    play(1, 1, 6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
